// File: rtl/l2_bank_tcdm_adapter.sv
// TCDM slave port to single-port SRAM strobes, plus a bank fill engine; grant is combinational, response 1 cycle later.
// No queuing: requests stall (gnt_o low) while a fill starts or runs; an in-flight response is always delivered.
module l2_bank_tcdm_adapter #(
    parameter int unsigned            ADDR_WIDTH = 14,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            BE_WIDTH   = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  init_ni,
    input  logic                  test_mode_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] add_i,
    input  logic                  wen_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  r_opc_o,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  init_done_o
);

    localparam logic [0:0]            RUN       = 1'b0;
    localparam logic [0:0]            FILL      = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                  csn;
        logic                  wen;
        logic [BE_WIDTH-1:0]   be;
        logic [ADDR_WIDTH-1:0] add;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_q;
    logic                  fill_start;
    logic                  fill_last;
    logic                  gnt;
    mem_req_t              mem_req;

    // A fill starts only on a falling edge of init_ni seen while idle; holding it low does nothing more.
    assign fill_start = init_q & ~init_ni & ~test_mode_i & (state_q == RUN);
    assign fill_last  = (state_q == FILL) && (cnt_q == LAST_ADDR);
    assign gnt        = req_i & ~fill_start & (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            if (fill_start) begin
                state_d = FILL;
                cnt_d   = '0;
            end
        end else begin
            if (fill_last) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ADDR_ONE;
            end
        end
    end

    always_comb begin
        mem_req.csn   = 1'b1;
        mem_req.wen   = 1'b1;
        mem_req.be    = '0;
        mem_req.add   = add_i;
        mem_req.wdata = wdata_i;
        if (state_q == FILL) begin
            mem_req.csn   = 1'b0;
            mem_req.wen   = 1'b0;
            mem_req.be    = {BE_WIDTH{1'b1}};
            mem_req.add   = cnt_q;
            mem_req.wdata = INIT_VALUE;
        end else if (gnt) begin
            mem_req.csn = 1'b0;
            mem_req.wen = wen_i;
            mem_req.be  = be_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            init_q      <= 1'b1;
            r_valid_o   <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_q    <= init_ni;
            r_valid_o <= gnt;
            if (fill_start) begin
                init_done_o <= 1'b0;
            end else if (fill_last) begin
                init_done_o <= 1'b1;
            end
        end
    end

    assign gnt_o       = gnt;
    assign r_rdata_o   = mem_rdata_i;
    assign r_opc_o     = 1'b0;
    assign mem_csn_o   = mem_req.csn;
    assign mem_wen_o   = mem_req.wen;
    assign mem_be_o    = mem_req.be;
    assign mem_add_o   = mem_req.add;
    assign mem_wdata_o = mem_req.wdata;

endmodule

// File: tb/tb_l2_bank_tcdm_adapter.sv
// Directed bench for l2_bank_tcdm_adapter with a behavioural 16-word bank and a response scoreboard.
module tb_l2_bank_tcdm_adapter;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam logic [DW-1:0] INIT = 32'hDEAD_BEEF;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          init_ni = 1'b1;
    logic          test_mode_i = 1'b0;
    logic          req_i = 1'b0;
    logic [AW-1:0] add_i = '0;
    logic          wen_i = 1'b1;
    logic [DW-1:0] wdata_i = '0;
    logic [BW-1:0] be_i = '0;
    logic          gnt_o, r_valid_o, r_opc_o, mem_csn_o, mem_wen_o, init_done_o;
    logic [DW-1:0] r_rdata_o, mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_add_o;

    typedef struct packed {
        logic          is_read;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] bank [0:15];

    l2_bank_tcdm_adapter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BE_WIDTH   (BW),
        .INIT_VALUE (INIT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .init_ni     (init_ni),
        .test_mode_i (test_mode_i),
        .req_i       (req_i),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .r_opc_o     (r_opc_o),
        .mem_csn_o   (mem_csn_o),
        .mem_wen_o   (mem_wen_o),
        .mem_be_o    (mem_be_o),
        .mem_add_o   (mem_add_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Single-port SRAM with 1-cycle read latency; output holds between reads.
    always @(posedge clk_i) begin
        if (!mem_csn_o) begin
            if (!mem_wen_o) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) bank[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= bank[mem_add_o];
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rst_ni && r_valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_r_valid: actual 1 required 0 (no response pending)");
            end else begin
                e = sb_q.pop_front();
                check("r_opc", {31'b0, r_opc_o}, 32'd0);
                if (e.is_read) check("r_rdata", r_rdata_o, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, input logic [DW-1:0] exp, output int waited);
        req_i = 1'b1; wen_i = wen; add_i = a; wdata_i = wd; be_i = be;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (gnt_o) begin
                sb_q.push_back(exp_t'{is_read: wen, data: exp});
                break;
            end
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: actual no grant required grant within 100 cycles");
        end
        tick();
        req_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w, nogrant, nwr, grants;
        logic done_early, found;

        #12;
        check("rst_csn", {31'b0, mem_csn_o}, 32'd1);
        check("rst_wen", {31'b0, mem_wen_o}, 32'd1);
        check("rst_be", {28'b0, mem_be_o}, 32'd0);
        check("rst_r_valid", {31'b0, r_valid_o}, 32'd0);
        check("rst_init_done", {31'b0, init_done_o}, 32'd0);
        check("rst_gnt", {31'b0, gnt_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Back-to-back write then read of address 3.
        issue(1'b0, 4'd3, 32'h1234_5678, 4'b1111, 32'h0, w);
        check("b2b_wr_wait", w, 0);
        issue(1'b1, 4'd3, 32'h0, 4'b1111, 32'h1234_5678, w);
        check("b2b_rd_wait", w, 0);
        check("b2b_rd_r_valid", {31'b0, r_valid_o}, 32'd1);
        check("b2b_rd_rdata", r_rdata_o, 32'h1234_5678);
        tick();

        // Byte-enable merge on address 5.
        issue(1'b0, 4'd5, 32'hAABB_CCDD, 4'b1111, 32'h0, w);
        issue(1'b0, 4'd5, 32'h1122_3344, 4'b0101, 32'h0, w);
        issue(1'b1, 4'd5, 32'h0, 4'b1111, 32'hAA22_CC44, w);
        tick();

        // One-cycle init pulse with a read of address 7 pending.
        req_i = 1'b1; wen_i = 1'b1; add_i = 4'd7; be_i = 4'b1111; init_ni = 1'b0;
        nogrant = 0; nwr = 0; done_early = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (gnt_o) begin
                check("fill_done_at_grant", {31'b0, init_done_o}, 32'd1);
                sb_q.push_back(exp_t'{is_read: 1'b1, data: INIT});
                break;
            end
            nogrant++;
            if (init_done_o) done_early = 1'b1;
            if (!mem_csn_o && !mem_wen_o) begin
                if (mem_add_o !== nwr[AW-1:0] || mem_wdata_o !== INIT || mem_be_o !== 4'b1111) begin
                    check("fill_add", {28'b0, mem_add_o}, nwr);
                    check("fill_wdata", mem_wdata_o, INIT);
                end
                nwr++;
            end
            tick();
            init_ni = 1'b1;
        end
        tick();
        req_i = 1'b0;
        check("fill_nogrant_cycles", nogrant, 17);
        check("fill_writes", nwr, 16);
        check("fill_done_early", {31'b0, done_early}, 32'd0);
        tick();

        // Holding init_ni low gives exactly one fill.
        init_ni = 1'b0;
        nwr = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk_i);
            if (!mem_csn_o && !mem_wen_o) nwr++;
            tick();
            if (i == 39) init_ni = 1'b1;
        end
        check("level_writes", nwr, 16);
        check("level_init_done", {31'b0, init_done_o}, 32'd1);

        // Same again in test mode: no fill, reads keep flowing.
        test_mode_i = 1'b1; init_ni = 1'b0;
        req_i = 1'b1; wen_i = 1'b1; add_i = 4'd7;
        nwr = 0; grants = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (gnt_o) begin
                grants++;
                sb_q.push_back(exp_t'{is_read: 1'b1, data: INIT});
            end
            if (!mem_csn_o && !mem_wen_o) nwr++;
            tick();
        end
        req_i = 1'b0; init_ni = 1'b1;
        tick();
        test_mode_i = 1'b0;
        check("tm_grants", grants, 40);
        check("tm_writes", nwr, 0);
        check("tm_init_done", {31'b0, init_done_o}, 32'd1);
        tick();

        // Read in cycle N, fill edge in N+1: response still carries pre-fill data.
        issue(1'b0, 4'd2, 32'hCAFE_0002, 4'b1111, 32'h0, w);
        issue(1'b1, 4'd2, 32'h0, 4'b1111, 32'hCAFE_0002, w);
        init_ni = 1'b0;
        check("ovl_r_valid", {31'b0, r_valid_o}, 32'd1);
        check("ovl_rdata", r_rdata_o, 32'hCAFE_0002);
        tick();
        init_ni = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (!mem_csn_o && !mem_wen_o && mem_add_o == 4'd9) begin
                found = 1'b1;
                break;
            end
        end
        check("ovl_reach_cnt9", {31'b0, found}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_r_valid", {31'b0, r_valid_o}, 32'd0);
        check("mid_rst_init_done", {31'b0, init_done_o}, 32'd0);
        check("mid_rst_csn", {31'b0, mem_csn_o}, 32'd1);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        issue(1'b0, 4'd9, 32'h5555_AAAA, 4'b1111, 32'h0, w);
        check("post_rst_wr_wait", w, 0);
        issue(1'b1, 4'd9, 32'h0, 4'b1111, 32'h5555_AAAA, w);
        check("post_rst_rd_wait", w, 0);
        check("post_rst_init_done", {31'b0, init_done_o}, 32'd0);
        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
